// File: rtl/gate_pkg.sv
// Shared types and constants for the gate truth-table exerciser.
// Truth tables are indexed by {x,y}.
package gate_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_exerciser_settle_timer.sv
// Loadable down-counter; zero flags the end of the settle window.
// Load wins over decrement, and the count parks at zero.
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       zero
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 4'd0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/gate_exerciser.sv
// Steps {x,y} through 00..11, samples z after a settle window and
// checks it against TRUTH; reports pass, failure mask and error count.
module gate_exerciser
    import gate_pkg::*;
#(
    parameter logic [3:0] TRUTH         = TT_NAND,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       z,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_vec
);

    localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fv_q, fv_d;
    logic       tmr_load, tmr_en, tmr_zero;

    settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (LOAD_VAL),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        fv_d     = fv_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d    = 2'd0;
                    err_d    = 3'd0;
                    fv_d     = 4'd0;
                    pass_d   = 1'b0;
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_zero)
                    state_d = SAMPLE;
                else
                    tmr_en = 1'b1;
            end
            SAMPLE: begin
                if (z != TRUTH[idx_q]) begin
                    fv_d[idx_q] = 1'b1;
                    err_d       = err_q + 3'd1;
                end
                // pass must see the final vector's compare made on this edge
                if (idx_q == 2'd3) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fv_d == 4'd0);
                    state_d = FINISH;
                end else begin
                    idx_d    = idx_q + 2'd1;
                    tmr_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fv_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
        end
    end

    assign x        = idx_q[1];
    assign y        = idx_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_vec = fv_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench: NAND-default exerciser with a modelled gate whose z can be
// forced, plus a SETTLE_CYCLES=1 instance wrapped around an AND gate.
module tb_gate_exerciser;
    import gate_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [1:0] zmode = 2'd0;   // 0: NAND gate, 1: tied 1, 2: tied 0
    logic       z0, x0, y0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [3:0] fv0;
    logic       z1, x1, y1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] fv1;
    int         n_cmp = 0, n_bad = 0;
    int         k, dpulses;

    always #5 clk = ~clk;

    assign z0 = (zmode == 2'd1) ? 1'b1 : (zmode == 2'd2) ? 1'b0 : ~(x0 & y0);
    assign z1 = x1 & y1;

    gate_exerciser #(.TRUTH(TT_NAND), .SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .z(z0), .x(x0), .y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fv0)
    );

    gate_exerciser #(.TRUTH(TT_AND), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .z(z1), .x(x1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge just after edge E0 (the edge that accepts start).
    task automatic pulse0();
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
    endtask

    // Edge count from E0 to the done pulse, -1 if it never shows.
    task automatic wait_done0(input int max, output int edges);
        edges = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_x", x0, 0);        chk("rst_y", y0, 0);
        chk("rst_busy", busy0, 0);  chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);  chk("rst_err", err0, 0);
        chk("rst_fv", fv0, 0);
        @(negedge clk) rst_n = 1'b1;

        // NAND gate, full run with vector stepping
        pulse0();
        chk("t1_busy_e0", busy0, 1);
        chk("t1_xy_e0", {x0, y0}, 8'b00);
        for (k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 4)  chk("t1_xy_e4", {x0, y0}, 8'b01);
            if (k == 7)  chk("t1_xy_e7", {x0, y0}, 8'b10);
            if (k == 10) chk("t1_xy_e10", {x0, y0}, 8'b11);
            if (k == 11) chk("t1_done_e11", done0, 0);
            if (k == 12) begin
                chk("t1_done_e12", done0, 1);
                chk("t1_busy_e12", busy0, 0);
                chk("t1_pass", pass0, 1);
                chk("t1_err", err0, 0);
                chk("t1_fv", fv0, 8'b0000);
            end
            if (k == 13) begin
                chk("t1_done_e13", done0, 0);
                chk("t1_xy_hold", {x0, y0}, 8'b11);
            end
        end

        // z stuck at 1: only vector 11 mismatches
        zmode = 2'd1;
        pulse0();
        wait_done0(20, k);
        chk("t2_edges", 8'(k), 12);
        chk("t2_fv", fv0, 8'b1000);
        chk("t2_err", err0, 1);
        chk("t2_pass", pass0, 0);

        // z stuck at 0: vectors 00,01,10 mismatch
        zmode = 2'd2;
        @(negedge clk);
        pulse0();
        chk("t3_pass_cleared", pass0, 0);
        wait_done0(20, k);
        chk("t3_edges", 8'(k), 12);
        chk("t3_fv", fv0, 8'b0111);
        chk("t3_err", err0, 3);
        chk("t3_pass", pass0, 0);

        // stray starts during SETTLE and FINISH are ignored
        zmode = 2'd0;
        @(negedge clk);
        pulse0();
        dpulses = 0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            start0 = (k == 1 || k == 12);
            if (done0 === 1'b1) dpulses++;
            if (k == 4)  chk("t4_xy_e4", {x0, y0}, 8'b01);
            if (k == 12) begin
                chk("t4_done_e12", done0, 1);
                chk("t4_busy_finish", busy0, 0);
            end
            if (k == 14) chk("t4_idle_busy", busy0, 0);
        end
        chk("t4_one_done", 8'(dpulses), 1);
        chk("t4_pass", pass0, 1);

        // reset asserted while vector 10 is applied
        zmode = 2'd2;
        @(negedge clk);
        pulse0();
        repeat (7) @(negedge clk);
        chk("t5_xy_pre", {x0, y0}, 8'b10);
        chk("t5_err_pre", err0, 2);
        rst_n = 1'b0;
        #1;
        chk("t5_x", x0, 0);       chk("t5_y", y0, 0);
        chk("t5_busy", busy0, 0); chk("t5_done", done0, 0);
        chk("t5_err", err0, 0);   chk("t5_fv", fv0, 0);
        chk("t5_pass", pass0, 0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        dpulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) dpulses++;
        end
        chk("t5_no_done", 8'(dpulses), 0);
        zmode = 2'd0;
        pulse0();
        wait_done0(20, k);
        chk("t5_rerun_edges", 8'(k), 12);
        chk("t5_rerun_pass", pass0, 1);
        chk("t5_rerun_fv", fv0, 0);

        // SETTLE_CYCLES=1 around an AND gate
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        k = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 2) chk("t6_xy_e2", {x1, y1}, 8'b01);
            if (done1 === 1'b1) begin
                k = i;
                break;
            end
        end
        chk("t6_edges", 8'(k), 8);
        chk("t6_pass", pass1, 1);
        chk("t6_fv", fv1, 0);
        chk("t6_err", err1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
